enemy_scheduler: RTL and testbench

Paces the enemy during a bout. Divides the system clock into move ticks, issues one-cycle `move` pulses that advance the enemy position controller, and counts moves. Once enough moves have been made it runs a punch sequence: windup, strike, block check, a damage handshake with the player-health logic, then recovery. It sits between the enemy position FSM and the player health/sprite logic and replaces free-running rate dividers with one sequenced counter.

---
 rtl/enemy_scheduler_if.sv | 24 ++
 rtl/enemy_scheduler.sv | 168 ++++++++++++++++
 tb/tb_enemy_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_scheduler_if.sv
// Handshake and status bundle between the enemy scheduler and the game logic.
// The master side is the game/health logic. The slave side is the scheduler.
interface enemy_scheduler_if;
    logic       enable;
    logic       aggressive;
    logic       dead;
    logic       block;
    logic       damage_ack;
    logic       move;
    logic [1:0] punch_state;
    logic       damage_req;
    logic       blocked;
    logic       halted;

    modport master (
        output enable, aggressive, dead, block, damage_ack,
        input  move, punch_state, damage_req, blocked, halted
    );

    modport slave (
        input  enable, aggressive, dead, block, damage_ack,
        output move, punch_state, damage_req, blocked, halted
    );
endinterface

// File: rtl/enemy_scheduler.sv
// Enemy pacing sequencer for a bout.
// A single down-counting divider produces move ticks. After enough moves, a
// punch runs: windup, strike, block check, damage handshake, then recovery.
// A dead enemy parks the block in HALT until reset.
module enemy_scheduler #(
    parameter int CALM_DIV    = 49_999_999,
    parameter int AGGR_DIV    = 24_999_999,
    parameter int WINDUP_CYC  = 25_000_000,
    parameter int RECOVER_CYC = 25_000_000,
    parameter int CNT_W       = 28
) (
    input  logic              clock,
    input  logic              reset,
    enemy_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_MOVE     = 3'd0,
        ST_WINDUP   = 3'd1,
        ST_STRIKE   = 3'd2,
        ST_DMG_WAIT = 3'd3,
        ST_RECOVER  = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CALM_LOAD    = CNT_W'(CALM_DIV);
    localparam logic [CNT_W-1:0] AGGR_LOAD    = CNT_W'(AGGR_DIV);
    localparam logic [CNT_W-1:0] WINDUP_LAST  = CNT_W'(WINDUP_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    // Sprite select for each state. STRIKE and DMG_WAIT share the strike pose.
    function automatic logic [1:0] punch_code(input state_t st);
        logic [1:0] code;
        case (st)
            ST_WINDUP:   code = 2'd1;
            ST_STRIKE:   code = 2'd2;
            ST_DMG_WAIT: code = 2'd2;
            ST_RECOVER:  code = 2'd3;
            default:     code = 2'd0;
        endcase
        return code;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] div_r, div_s;
    logic [CNT_W-1:0] phase_r, phase_s;
    logic [1:0]       cnt_r, cnt_s;
    logic [CNT_W-1:0] reload_s;
    logic [1:0]       thresh_s;
    logic             move_r, move_s;
    logic             blocked_r, blocked_s;
    logic [1:0]       punch_r, punch_s;
    logic             damage_req_r, damage_req_s;
    logic             halted_r, halted_s;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_s  = state_r;
        div_s    = div_r;
        phase_s  = phase_r;
        cnt_s    = cnt_r;
        move_s   = 1'b0;
        blocked_s = 1'b0;
        reload_s = bus.aggressive ? AGGR_LOAD : CALM_LOAD;
        thresh_s = bus.aggressive ? 2'd1 : 2'd3;

        if (bus.dead) begin
            // Death wins over acks and ticks, even while paused.
            state_s = ST_HALT;
        end else if ((state_r == ST_HALT) || !bus.enable) begin
            state_s = state_r;
        end else begin
            case (state_r)
                ST_MOVE: begin
                    if (div_r == CNT_ZERO) begin
                        div_s = reload_s;
                        // >= also catches a threshold drop when aggression rises mid-count.
                        if (cnt_r >= thresh_s) begin
                            cnt_s   = 2'd0;
                            phase_s = CNT_ZERO;
                            state_s = ST_WINDUP;
                        end else begin
                            cnt_s  = cnt_r + 2'd1;
                            move_s = 1'b1;
                        end
                    end else begin
                        div_s = div_r - CNT_ONE;
                    end
                end
                ST_WINDUP: begin
                    if (phase_r == WINDUP_LAST) begin
                        phase_s = CNT_ZERO;
                        state_s = ST_STRIKE;
                    end else begin
                        phase_s = phase_r + CNT_ONE;
                    end
                end
                ST_STRIKE: begin
                    phase_s = CNT_ZERO;
                    if (bus.block) begin
                        blocked_s = 1'b1;
                        state_s   = ST_RECOVER;
                    end else begin
                        state_s = ST_DMG_WAIT;
                    end
                end
                ST_DMG_WAIT: begin
                    if (bus.damage_ack) begin
                        phase_s = CNT_ZERO;
                        state_s = ST_RECOVER;
                    end else begin
                        state_s = ST_DMG_WAIT;
                    end
                end
                ST_RECOVER: begin
                    if (phase_r == RECOVER_LAST) begin
                        phase_s = CNT_ZERO;
                        div_s   = reload_s;
                        state_s = ST_MOVE;
                    end else begin
                        phase_s = phase_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_HALT;
                end
            endcase
        end

        punch_s      = punch_code(state_s);
        damage_req_s = (state_s == ST_DMG_WAIT);
        halted_s     = (state_s == ST_HALT);
    end

    // State, counters and outputs; reset clears everything without a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_MOVE;
            div_r        <= CALM_LOAD;
            phase_r      <= CNT_ZERO;
            cnt_r        <= 2'd0;
            move_r       <= 1'b0;
            blocked_r    <= 1'b0;
            punch_r      <= 2'd0;
            damage_req_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            div_r        <= div_s;
            phase_r      <= phase_s;
            cnt_r        <= cnt_s;
            move_r       <= move_s;
            blocked_r    <= blocked_s;
            punch_r      <= punch_s;
            damage_req_r <= damage_req_s;
            halted_r     <= halted_s;
        end
    end

    assign bus.move        = move_r;
    assign bus.blocked     = blocked_r;
    assign bus.punch_state = punch_r;
    assign bus.damage_req  = damage_req_r;
    assign bus.halted      = halted_r;

endmodule

// File: tb/tb_enemy_scheduler.sv
// Randomized scoreboard bench for enemy_scheduler.
// The driver steps a behavioural model on every falling edge and queues the
// outputs expected after the next rising edge. A monitor pops the queue and
// compares shortly after each rising edge.
module tb_enemy_scheduler;

    localparam int CALM = 3;
    localparam int AGGR = 1;
    localparam int WIN  = 2;
    localparam int REC  = 2;

    localparam int M_MOVE    = 0;
    localparam int M_WINDUP  = 1;
    localparam int M_STRIKE  = 2;
    localparam int M_DMGWAIT = 3;
    localparam int M_RECOVER = 4;
    localparam int M_HALT    = 5;

    typedef struct packed {
        logic       mv;
        logic [1:0] ps;
        logic       dreq;
        logic       blk;
        logic       hlt;
    } exp_t;

    logic clock;
    logic reset;
    enemy_scheduler_if bus();

    enemy_scheduler #(
        .CALM_DIV(CALM), .AGGR_DIV(AGGR), .WINDUP_CYC(WIN),
        .RECOVER_CYC(REC), .CNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_got;

    // Model state: mode, enabled cycles in the current tick period, period length,
    // moves made, cycles left in windup or recovery.
    int m_mode, m_elapsed, m_period, m_moves, m_left;
    logic cur_aggr;

    task automatic model_reset();
        m_mode    = M_MOVE;
        m_elapsed = 0;
        m_period  = CALM + 1;
        m_moves   = 0;
        m_left    = 0;
    endtask

    task automatic model_step(input logic en, input logic ag, input logic dd,
                              input logic bl, input logic ak, output exp_t e);
        e = '0;
        if (dd) begin
            m_mode = M_HALT;
        end else if (m_mode != M_HALT && en) begin
            case (m_mode)
                M_MOVE: begin
                    m_elapsed++;
                    if (m_elapsed >= m_period) begin
                        m_elapsed = 0;
                        m_period  = (ag ? AGGR : CALM) + 1;
                        if (m_moves >= (ag ? 1 : 3)) begin
                            m_moves = 0;
                            m_mode  = M_WINDUP;
                            m_left  = WIN;
                        end else begin
                            m_moves++;
                            e.mv = 1'b1;
                        end
                    end
                end
                M_WINDUP: begin
                    m_left--;
                    if (m_left == 0) m_mode = M_STRIKE;
                end
                M_STRIKE: begin
                    if (bl) begin
                        e.blk  = 1'b1;
                        m_mode = M_RECOVER;
                        m_left = REC;
                    end else begin
                        m_mode = M_DMGWAIT;
                    end
                end
                M_DMGWAIT: begin
                    if (ak) begin
                        m_mode = M_RECOVER;
                        m_left = REC;
                    end
                end
                M_RECOVER: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode    = M_MOVE;
                        m_elapsed = 0;
                        m_period  = (ag ? AGGR : CALM) + 1;
                    end
                end
                default: m_mode = M_HALT;
            endcase
        end
        case (m_mode)
            M_WINDUP:  e.ps = 2'd1;
            M_STRIKE:  e.ps = 2'd2;
            M_DMGWAIT: e.ps = 2'd2;
            M_RECOVER: e.ps = 2'd3;
            default:   e.ps = 2'd0;
        endcase
        e.dreq = (m_mode == M_DMGWAIT);
        e.hlt  = (m_mode == M_HALT);
    endtask

    // One clock of stimulus: drive on the falling edge and queue the expectation.
    task automatic step(input logic en, input logic ag, input logic dd,
                        input logic bl, input logic ak, input logic rs);
        exp_t e;
        @(negedge clock);
        reset          = rs;
        bus.enable     = en;
        bus.aggressive = ag;
        bus.dead       = dd;
        bus.block      = bl;
        bus.damage_ack = ak;
        if (rs) begin
            model_reset();
            e = '0;
        end else begin
            model_step(en, ag, dd, bl, ak, e);
        end
        exp_q.push_back(e);
    endtask

    function automatic logic pct(input int p);
        return ($urandom_range(99) < p);
    endfunction

    // aggr_mode: 0 calm, 1 aggressive, 2 occasional random flips.
    task automatic run_random(input int n, input int p_en, input int aggr_mode,
                              input int p_bl, input int p_ak, input int p_dead);
        for (int i = 0; i < n; i++) begin
            if (aggr_mode == 0) cur_aggr = 1'b0;
            else if (aggr_mode == 1) cur_aggr = 1'b1;
            else if (pct(5)) cur_aggr = ~cur_aggr;
            step(pct(p_en), cur_aggr, pct(p_dead), pct(p_bl), pct(p_ak), 1'b0);
        end
    endtask

    // Step calm with enable high until the model is about to enter the target mode.
    task automatic wait_mode(input int target, input int budget, input logic bl);
        int n;
        n = 0;
        cur_aggr = 1'b0;
        while (m_mode != target && n < budget) begin
            step(1'b1, 1'b0, 1'b0, bl, 1'b0, 1'b0);
            n++;
        end
        if (m_mode != target) begin
            checks++;
            errors++;
            $display("FAIL wait_mode: target mode %0d not reached within %0d cycles (model mode %0d)",
                     target, budget, m_mode);
        end
    endtask

    // Monitor: compare one queued expectation just after each rising edge.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {bus.move, bus.punch_state, bus.damage_req, bus.blocked, bus.halted};
            checks++;
            if (mon_got !== mon_e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got mv=%b ps=%0d dreq=%b blk=%b hlt=%b expected mv=%b ps=%0d dreq=%b blk=%b hlt=%b",
                         $time, mon_got.mv, mon_got.ps, mon_got.dreq, mon_got.blk, mon_got.hlt,
                         mon_e.mv, mon_e.ps, mon_e.dreq, mon_e.blk, mon_e.hlt);
            end
        end
    end

    task automatic check_zero(input string name);
        exp_t got;
        got = {bus.move, bus.punch_state, bus.damage_req, bus.blocked, bus.halted};
        checks++;
        if (got !== 6'b0) begin
            errors++;
            $display("FAIL %s: outputs=%b required=000000", name, got);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.aggressive = 1'b0;
        bus.dead       = 1'b0;
        bus.block      = 1'b0;
        bus.damage_ack = 1'b0;
        cur_aggr       = 1'b0;
        model_reset();
        #1;
        check_zero("reset_values");

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Calm pacing with every strike blocked.
        run_random(40, 100, 0, 100, 0, 0);
        // Calm pacing, strikes land, slow random acks.
        run_random(40, 100, 0, 0, 20, 0);
        // Aggressive pacing.
        run_random(60, 100, 1, 50, 30, 0);
        // Random pauses and aggression flips.
        run_random(300, 70, 2, 50, 25, 0);

        // Asynchronous reset in the middle of windup.
        wait_mode(M_WINDUP, 200, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check_zero("async_reset_mid_windup");
        run_random(30, 100, 0, 0, 30, 0);

        // Death during the damage handshake while an ack is also presented.
        wait_mode(M_DMGWAIT, 200, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_random(50, 70, 2, 50, 50, 30);

        @(posedge clock);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
